// File: rtl/vce_pkg.sv
// Shared types for the VCE video path: 9-bit pixel in VCE bit order and the
// scan doubler's output sequencing states.
package vce_pkg;
  localparam int VCE_LINE_W = 512;
  localparam int LB_AW = $clog2(VCE_LINE_W);

  typedef struct packed {
    logic [2:0] g;
    logic [2:0] r;
    logic [2:0] b;
  } rgb9_t;

  typedef enum logic [1:0] {IDLE, PASS0, PASS1} out_state_t;
endpackage

// File: rtl/vce_line_ram.sv
// Simple dual-port line store: one write port, one registered read port.
module vce_line_ram
  import vce_pkg::*;
#(
  parameter int DEPTH = 2 * VCE_LINE_W
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  rgb9_t                    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output rgb9_t                    rdata
);
  rgb9_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/vce_scan_doubler.sv
// 15 kHz -> 31 kHz line doubler: each completed input line is played out twice
// from a ping-pong line buffer with regenerated output syncs.
module vce_scan_doubler
  import vce_pkg::*;
#(
  parameter int LINE_W         = VCE_LINE_W,
  parameter int OUT_DIV        = 2,
  parameter int HSYNC_OUT_CLKS = 64,
  parameter int ACTIVE_START   = 96,
  parameter int ACTIVE_W       = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [2:0]  VIDEO_R,
  input  logic [2:0]  VIDEO_G,
  input  logic [2:0]  VIDEO_B,
  input  logic        HSYN,
  input  logic        VSYN,
  output logic [2:0]  VGA_R,
  output logic [2:0]  VGA_G,
  output logic [2:0]  VGA_B,
  output logic        VGA_HS_n,
  output logic        VGA_VS_n,
  output logic        VGA_DE,
  output logic [15:0] line_len,
  output logic        overflow
);
  localparam int AW      = $clog2(LINE_W);
  localparam int ACT_END = ACTIVE_START + ACTIVE_W * OUT_DIV;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic de;
  } sync_t;

  logic        hs_d, hfall, we, wr_buf, rd_buf, valid;
  logic [AW:0] wr_x;
  logic [15:0] lcnt, oc, half, ll_nxt, oc_rel;
  logic [AW-1:0] rd_x;
  logic        hs_raw, de_raw;
  out_state_t  state;
  rgb9_t       ram_q, out_pix;
  sync_t       s1;

  assign hfall  = hs_d & ~HSYN;
  assign we     = ~reset & ~hfall & pix_en & HSYN & (wr_x < (AW+1)'(LINE_W));
  assign ll_nxt = valid ? ((lcnt == 16'hFFFF) ? 16'hFFFF : lcnt + 16'd1) : line_len;
  assign half   = line_len >> 1;

  assign oc_rel = oc - 16'(ACTIVE_START);
  assign rd_x   = AW'(oc_rel / 16'(OUT_DIV));
  assign hs_raw = (state == IDLE) || (oc >= 16'(HSYNC_OUT_CLKS));
  assign de_raw = (state != IDLE) && (oc >= 16'(ACTIVE_START)) && (oc < 16'(ACT_END));

  vce_line_ram #(.DEPTH(2 * LINE_W)) u_ram (
    .clock (clock),
    .we    (we),
    .waddr ({wr_buf, wr_x[AW-1:0]}),
    .wdata ('{g: VIDEO_G, r: VIDEO_R, b: VIDEO_B}),
    .raddr ({rd_buf, rd_x}),
    .rdata (ram_q)
  );

  // hfall wins over every write-side and sequencing action in its cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      hs_d     <= 1'b0;
      wr_buf   <= 1'b0;
      rd_buf   <= 1'b0;
      wr_x     <= '0;
      valid    <= 1'b0;
      lcnt     <= '0;
      line_len <= '0;
      overflow <= 1'b0;
      oc       <= '0;
      state    <= IDLE;
    end else begin
      hs_d <= HSYN;
      lcnt <= hfall ? 16'd0 : ((lcnt == 16'hFFFF) ? lcnt : lcnt + 16'd1);
      if (hfall) begin
        wr_buf   <= ~wr_buf;
        wr_x     <= '0;
        valid    <= 1'b1;
        line_len <= ll_nxt;
        rd_buf   <= wr_buf;
        oc       <= '0;
        state    <= (ll_nxt >= 16'd2) ? PASS0 : IDLE;
      end else begin
        if (we) wr_x <= wr_x + 1'b1;
        else if (pix_en & HSYN) overflow <= 1'b1;
        case (state)
          PASS0: begin
            if (oc == half - 16'd1) begin
              oc    <= '0;
              state <= PASS1;
            end else oc <= oc + 16'd1;
          end
          PASS1: begin
            if (oc == half - 16'd1) state <= IDLE;
            else oc <= oc + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // syncs ride one stage alongside the RAM read so all outputs stay aligned
  always_ff @(posedge clock) begin
    if (reset) begin
      s1       <= '{hs_n: 1'b1, vs_n: 1'b1, de: 1'b0};
      VGA_HS_n <= 1'b1;
      VGA_VS_n <= 1'b1;
      VGA_DE   <= 1'b0;
      out_pix  <= '0;
    end else begin
      s1       <= '{hs_n: hs_raw, vs_n: VSYN, de: de_raw};
      VGA_HS_n <= s1.hs_n;
      VGA_VS_n <= s1.vs_n;
      VGA_DE   <= s1.de;
      out_pix  <= s1.de ? ram_q : '0;
    end
  end

  assign VGA_R = out_pix.r;
  assign VGA_G = out_pix.g;
  assign VGA_B = out_pix.b;
endmodule

// File: tb/tb_vce_scan_doubler.sv
// Scoreboarded bench: a time-based reference model predicts every output cycle,
// a monitor pops and compares each cycle the DUT presents.
module tb_vce_scan_doubler;
  localparam int LINE_W = 512;

  logic clock = 1'b1;
  logic reset, pix_en, HSYN, VSYN;
  logic [2:0] VIDEO_R, VIDEO_G, VIDEO_B;
  logic [2:0] VGA_R, VGA_G, VGA_B;
  logic VGA_HS_n, VGA_VS_n, VGA_DE, overflow;
  logic [15:0] line_len;

  vce_scan_doubler dut (
    .clock(clock), .reset(reset), .pix_en(pix_en),
    .VIDEO_R(VIDEO_R), .VIDEO_G(VIDEO_G), .VIDEO_B(VIDEO_B),
    .HSYN(HSYN), .VSYN(VSYN),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS_n(VGA_HS_n), .VGA_VS_n(VGA_VS_n), .VGA_DE(VGA_DE),
    .line_len(line_len), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {bit hs; bit de; bit chk; logic [8:0] pix;} st_t;
  typedef struct {bit hs; bit vs; bit de; bit chk; logic [8:0] pix;} exp_t;

  int total = 0, bad = 0;
  exp_t sbq[$];

  task automatic check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] m_cur[$], m_disp[$];
  int  edge_n = 0, m_last_h = 0, m_org = 0, m_half = 1, m_ll = 0;
  bit  m_prev_hs = 0, m_valid = 0, m_ovf = 0, m_on = 0;
  st_t st_m1 = '{hs: 1, de: 0, chk: 1, pix: 0};
  st_t st_m2 = '{hs: 1, de: 0, chk: 1, pix: 0};
  bit  vs_m1 = 1, rst_m1 = 1;

  always @(negedge clock) begin
    st_t s;
    exp_t e;
    int el, oc, idx;
    if (reset) begin
      m_prev_hs = 0; m_valid = 0; m_ll = 0; m_ovf = 0; m_on = 0;
      m_cur.delete();
    end else begin
      if (m_prev_hs && !HSYN) begin
        if (m_valid) m_ll = (edge_n - m_last_h > 65535) ? 65535 : edge_n - m_last_h;
        m_valid = 1; m_last_h = edge_n;
        m_disp = m_cur; m_cur.delete();
        m_on = (m_ll >= 2); m_org = edge_n; m_half = m_ll / 2;
      end else if (pix_en && HSYN) begin
        if (m_cur.size() < LINE_W) m_cur.push_back({VIDEO_G, VIDEO_R, VIDEO_B});
        else m_ovf = 1;
      end
      m_prev_hs = HSYN;
    end
    s = '{hs: 1, de: 0, chk: 1, pix: 0};
    el = edge_n - m_org;
    if (!reset && m_on && el < 2 * m_half) begin
      oc = el % m_half;
      s.hs = (oc >= 64);
      s.de = (oc >= 96 && oc < 96 + 512);
      if (s.de) begin
        idx = (oc - 96) / 2;
        if (idx < m_disp.size()) s.pix = m_disp[idx];
        else s.chk = 0;
      end
    end
    if (reset || rst_m1) e = '{hs: 1, vs: 1, de: 0, chk: 1, pix: 0};
    else e = '{hs: st_m2.hs, vs: vs_m1, de: st_m2.de, chk: st_m2.chk, pix: st_m2.pix};
    sbq.push_back(e);
    st_m2 = st_m1; st_m1 = s; vs_m1 = VSYN; rst_m1 = reset;
    edge_n++;
  end

  // ---------------- monitor ----------------
  int cyc = 0, de_cnt = 0, hs_run = 0;
  bit prev_de = 0, prev_hs = 1;
  int hs_falls[$], de_rises[$];

  always @(posedge clock) begin
    exp_t e;
    logic [11:0] a, x;
    #1;
    cyc++;
    if (VGA_DE === 1'b1 && !prev_de) de_rises.push_back(cyc);
    if (VGA_DE === 1'b1) de_cnt++;
    if (VGA_HS_n === 1'b0) begin
      if (prev_hs) hs_falls.push_back(cyc);
      hs_run++;
    end else if (hs_run > 0) begin
      check("hs_low_width", hs_run, 64);
      hs_run = 0;
    end
    prev_de = (VGA_DE === 1'b1);
    prev_hs = (VGA_HS_n !== 1'b0);
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty at cycle %0d", cyc);
    end else begin
      e = sbq.pop_front();
      a = {VGA_HS_n, VGA_VS_n, VGA_DE, VGA_G, VGA_R, VGA_B};
      x = {e.hs, e.vs, e.de, e.pix};
      if (!e.chk) begin
        a[8:0] = '0;
        x[8:0] = '0;
      end
      if (a !== x) begin
        bad++;
        $display("FAIL vga_out cyc=%0d got hs/vs/de/rgb=%03h expected=%03h", cyc, a, x);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ramp=1: pixel value = index; gap_rand=1: random spacing 1..gap
  task automatic drive_line(int len, int hs_w, bit ramp, bit vs, int npix, int gap,
                            bit gap_rand, bit pix_on_hfall, int rst_at);
    int p = 0, nxt = hs_w;
    logic [8:0] v;
    for (int c = 0; c < len; c++) begin
      HSYN   = (c < hs_w) ? 1'b0 : 1'b1;
      VSYN   = ~vs;
      reset  = (c == rst_at);
      pix_en = 1'b0;
      v      = 9'($urandom);
      if (pix_on_hfall && c == 0) begin
        pix_en = 1'b1;
        {VIDEO_G, VIDEO_R, VIDEO_B} = v | 9'h1;
      end else if (c == nxt && p < npix) begin
        pix_en = 1'b1;
        {VIDEO_G, VIDEO_R, VIDEO_B} = ramp ? 9'(p) : v;
        p++;
        nxt = c + (gap_rand ? $urandom_range(gap, 1) : gap);
      end
      tick();
    end
    reset  = 1'b0;
    pix_en = 1'b0;
    check("line_len_model", line_len, m_ll);
    check("overflow_model", overflow, m_ovf);
  endtask

  initial begin
    reset = 1; pix_en = 0; HSYN = 1; VSYN = 1;
    {VIDEO_G, VIDEO_R, VIDEO_B} = '0;
    repeat (4) tick();
    reset = 0;
    repeat (10) tick();
    check("line_len_reset", line_len, 0);
    check("overflow_reset", overflow, 0);

    drive_line(1364, 64, 1, 0, 256, 4, 0, 0, -1);
    hs_falls.delete(); de_rises.delete(); de_cnt = 0;
    drive_line(1364, 64, 0, 0, 300, 4, 1, 0, -1);
    check("line_len_1364", line_len, 1364);
    check("hs_fall_count", hs_falls.size(), 2);
    check("de_rise_count", de_rises.size(), 2);
    if (hs_falls.size() >= 2) check("hs_pass_gap", hs_falls[1] - hs_falls[0], 682);
    if (hs_falls.size() >= 1 && de_rises.size() >= 1)
      check("first_active_ofs", de_rises[0] - hs_falls[0], 96);
    check("de_clocks_two_passes", de_cnt, 1024);

    drive_line(1364, 1, 0, 0, 300, 4, 1, 1, -1);
    for (int i = 0; i < 3; i++) drive_line(1364, 64, 0, 1, 300, 4, 1, 0, -1);
    drive_line(1364, 64, 0, 0, 300, 4, 1, 0, -1);
    drive_line(2728, 64, 0, 0, 400, 4, 1, 0, -1);
    check("line_len_stretched", line_len, 1364);
    drive_line(1364, 64, 0, 0, 300, 4, 1, 0, -1);
    check("line_len_after_skip", line_len, 2728);
    drive_line(1364, 64, 0, 0, 300, 4, 1, 0, -1);
    drive_line(1364, 64, 0, 0, 300, 4, 1, 0, 400);
    check("line_len_after_mid_reset", line_len, 0);
    for (int i = 0; i < 3; i++) drive_line(1364, 64, 0, 0, 300, 4, 1, 0, -1);

    drive_line(1364, 64, 0, 0, 520, 2, 0, 0, -1);
    check("overflow_set", overflow, 1);
    drive_line(1364, 64, 0, 0, 300, 4, 1, 0, -1);
    check("overflow_sticky", overflow, 1);
    reset = 1;
    tick();
    reset = 0;
    tick();
    check("overflow_cleared", overflow, 0);

    for (int i = 0; i < 5; i++)
      drive_line($urandom_range(1500, 1200), 64, 0, $urandom_range(1, 0), 300, 4, 1, 0, -1);
    HSYN = 1; VSYN = 1;
    repeat (1600) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
